// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB-first, WIDTH cycles per operation.
// Defining SERIAL_ADDER_OVF_EN adds the ovf output (signed overflow flag).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             c_next;
    logic             last_bit;

    assign bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (state == RUN) && (cnt == LAST);

    assign sum  = sum_r;
    assign cout = cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            cout_r    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter from the MSB side so bit 0 lands at sum[0] after WIDTH shifts.
                    sum_r <= {bit_s, sum_r[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_r    <= c_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is the carry flop during the last bit; carry out is c_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= carry ^ c_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Build with SERIAL_ADDER_OVF_EN defined to also check the ovf output.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid and returns how many edges that took.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir_high"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        bit seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h00);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Operands waiting at release are taken on the first edge afterwards
        a        = 8'h5A;
        b        = 8'h3C;
        cin      = 1'b0;
        in_valid = 1'b1;
        rst_n    = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("v1_accept", 32'(in_ready), 32'd0);
        wait_done(n);
        chk("v1_latency", 32'(n), 32'd8);
        chk("v1_sum", 32'(sum), 32'h96);
        chk("v1_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("v1_ovf", 32'(ovf), 32'd1);
`endif
        release_result("v1");

        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(n);
        chk("v2_latency", 32'(n), 32'd8);
        chk("v2_sum", 32'(sum), 32'h00);
        chk("v2_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("v2_ovf", 32'(ovf), 32'd0);
`endif
        release_result("v2");

        start_op(8'h7F, 8'h00, 1'b1);
        wait_done(n);
        chk("v3_latency", 32'(n), 32'd8);
        chk("v3_sum", 32'(sum), 32'h80);
        chk("v3_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("v3_ovf", 32'(ovf), 32'd1);
`endif
        release_result("v3");

        // Back-pressure: result held for 5 cycles with out_ready low
        start_op(8'hC8, 8'h64, 1'b1);
        wait_done(n);
        chk("bp_latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum", 32'(sum), 32'h2D);
            chk("bp_cout", 32'(cout), 32'd1);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        // New operands on the release edge must not be taken
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        release_result("bp");
        in_valid = 1'b0;
        tick();
        chk("bp_no_accept", 32'(in_ready), 32'd1);

        // in_valid kept high with changing operands during RUN is ignored
        start_op(8'h10, 8'h20, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a   = 8'hAA;
            b   = 8'h55;
            cin = 1'b1;
            tick();
        end
        wait_done(n);
        in_valid = 1'b0;
        chk("ign_latency", 32'(n), 32'd5);
        chk("ign_sum", 32'(sum), 32'h30);
        chk("ign_cout", 32'(cout), 32'd0);
        release_result("ign");

        // Reset in the middle of RUN discards the operation
        start_op(8'hC3, 8'h3C, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ab_out_valid", 32'(out_valid), 32'd0);
        chk("ab_sum", 32'(sum), 32'h00);
        chk("ab_in_ready", 32'(in_ready), 32'd1);
        chk("ab_cout", 32'(cout), 32'd0);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("ab_no_pulse", 32'(seen), 32'd0);
        chk("ab_idle", 32'(in_ready), 32'd1);

        start_op(8'h01, 8'h02, 1'b0);
        wait_done(n);
        chk("post_latency", 32'(n), 32'd8);
        chk("post_sum", 32'(sum), 32'h03);
        chk("post_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("post_ovf", 32'(ovf), 32'd0);
`endif
        release_result("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
